// File: rtl/elevator_scan_ctrl.sv
// SCAN-scheduled elevator controller: IDLE / MOVE / DOOR_OPEN with persistent direction.
// Optional door-hold input enabled by defining ELEVATOR_DOOR_HOLD_EN.
module elevator_scan_ctrl #(
    parameter int FLOORS       = 4,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FLOORS-1:0]          interior_panel,
    input  logic [FLOORS-1:0]          exterior_panel,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                       door_hold,
`endif
    output logic [1:0]                 engine,
    output logic [FLOORS-1:0]          doors,
    output logic [$clog2(FLOORS)-1:0]  floor,
    output logic [FLOORS-1:0]          pending
);

    localparam int FW = $clog2(FLOORS);
    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [FW-1:0] TOP = FW'(FLOORS - 1);
    localparam logic [TW-1:0] T_LOAD = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(DOOR_TICKS - 1);
    localparam logic [1:0] ENG_OFF  = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b10;
    localparam logic [1:0] ENG_DOWN = 2'b11;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN} state_t;

    state_t            state, state_n;
    logic              dir, dir_n;
    logic [FW-1:0]     floor_n, nf;
    logic [1:0]        engine_n;
    logic [FLOORS-1:0] doors_n, pend_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [DW-1:0]     dcnt, dcnt_n;
    logic [FLOORS-1:0] req, here, nhere;
    logic              up_any, dn_any, up_nf, dn_nf;
    logic              hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
        logic [FLOORS-1:0] one;
        one = {{(FLOORS-1){1'b0}}, 1'b1};
        return one << f;
    endfunction

    function automatic logic [FLOORS-1:0] above(input logic [FW-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] below(input logic [FW-1:0] f);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    always_comb begin
        req    = interior_panel | exterior_panel;
        here   = onehot(floor);
        nf     = floor;
        if (dir && floor != TOP)
            nf = floor + 1'b1;
        else if (!dir && floor != '0)
            nf = floor - 1'b1;
        nhere  = onehot(nf);
        up_any = |(pending & above(floor));
        dn_any = |(pending & below(floor));
        up_nf  = |(pending & above(nf));
        dn_nf  = |(pending & below(nf));

        state_n  = state;
        floor_n  = floor;
        dir_n    = dir;
        engine_n = engine;
        doors_n  = doors;
        pend_n   = pending | req;
        tcnt_n   = tcnt;
        dcnt_n   = dcnt;

        case (state)
            IDLE: begin
                pend_n   = pending | (req & ~here);
                engine_n = ENG_OFF;
                doors_n  = '0;
                if (((req | pending) & here) != '0) begin
                    state_n = DOOR_OPEN;
                    doors_n = here;
                    pend_n  = pend_n & ~here;
                    dcnt_n  = D_LOAD;
                end else if ((dir && up_any) || (!dn_any && up_any)) begin
                    state_n  = MOVE;
                    dir_n    = 1'b1;
                    engine_n = ENG_UP;
                    tcnt_n   = T_LOAD;
                end else if (dn_any) begin
                    state_n  = MOVE;
                    dir_n    = 1'b0;
                    engine_n = ENG_DOWN;
                    tcnt_n   = T_LOAD;
                end
            end
            MOVE: begin
                if (tcnt != '0) begin
                    tcnt_n = tcnt - 1'b1;
                end else begin
                    tcnt_n  = T_LOAD;
                    floor_n = nf;
                    if (nf == TOP) dir_n = 1'b0;
                    if (nf == '0)  dir_n = 1'b1;
                    // Arrival clear beats a same-edge request for this floor
                    if ((pending & nhere) != '0) begin
                        state_n  = DOOR_OPEN;
                        pend_n   = (pending | req) & ~nhere;
                        engine_n = ENG_OFF;
                        doors_n  = nhere;
                        dcnt_n   = D_LOAD;
                    end else if (!(dir ? up_nf : dn_nf)) begin
                        state_n  = IDLE;
                        engine_n = ENG_OFF;
                    end
                end
            end
            DOOR_OPEN: begin
                pend_n = pending | (req & ~here);
                if (((req & here) != '0) || hold) begin
                    dcnt_n = D_LOAD;
                end else if (dcnt == '0) begin
                    state_n = IDLE;
                    doors_n = '0;
                end else begin
                    dcnt_n = dcnt - 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                engine_n = ENG_OFF;
                doors_n  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            floor   <= '0;
            dir     <= 1'b1;
            engine  <= ENG_OFF;
            doors   <= '0;
            pending <= '0;
            tcnt    <= '0;
            dcnt    <= '0;
        end else begin
            state   <= state_n;
            floor   <= floor_n;
            dir     <= dir_n;
            engine  <= engine_n;
            doors   <= doors_n;
            pending <= pend_n;
            tcnt    <= tcnt_n;
            dcnt    <= dcnt_n;
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl, FLOORS=4, TRAVEL_TICKS=4, DOOR_TICKS=3.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_elevator_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] interior_panel = '0;
    logic [3:0] exterior_panel = '0;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold = 1'b0;
`endif
    logic [1:0] engine;
    logic [3:0] doors;
    logic [1:0] floor;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;

    elevator_scan_ctrl #(
        .FLOORS(4), .TRAVEL_TICKS(4), .DOOR_TICKS(3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .interior_panel(interior_panel),
        .exterior_panel(exterior_panel),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .engine(engine),
        .doors(doors),
        .floor(floor),
        .pending(pending)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++; if (engine !== 2'b00) begin bad++; $display("FAIL rst_engine got=%b exp=00", engine); end
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL rst_doors got=%b exp=0000", doors); end
        total++; if (floor !== 2'd0) begin bad++; $display("FAIL rst_floor got=%0d exp=0", floor); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL rst_pending got=%b exp=0000", pending); end
        #10;
        RST = 1'b1;
        tick(1);
    endtask

    task automatic test_single_up;
        interior_panel = 4'b0100;
        tick(1);
        interior_panel = '0;
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL up_t0_pending got=%b exp=0100", pending); end
        total++; if (engine !== 2'b00) begin bad++; $display("FAIL up_t0_engine got=%b exp=00", engine); end
        tick(1);
        total++; if (engine !== 2'b10) begin bad++; $display("FAIL up_t1_engine got=%b exp=10", engine); end
        tick(4);
        total++; if (floor !== 2'd1) begin bad++; $display("FAIL up_t5_floor got=%0d exp=1", floor); end
        total++; if (engine !== 2'b10) begin bad++; $display("FAIL up_t5_engine got=%b exp=10", engine); end
        tick(4);
        total++; if (floor !== 2'd2) begin bad++; $display("FAIL up_t9_floor got=%0d exp=2", floor); end
        total++; if (engine !== 2'b00) begin bad++; $display("FAIL up_t9_engine got=%b exp=00", engine); end
        total++; if (doors !== 4'b0100) begin bad++; $display("FAIL up_t9_doors got=%b exp=0100", doors); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL up_t9_pending got=%b exp=0000", pending); end
        tick(2);
        total++; if (doors !== 4'b0100) begin bad++; $display("FAIL up_t11_doors got=%b exp=0100", doors); end
        tick(1);
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL up_t12_doors got=%b exp=0000", doors); end
    endtask

    task automatic test_scan;
        exterior_panel = 4'b1001;
        tick(1);
        exterior_panel = '0;
        tick(1);
        total++; if (engine !== 2'b10) begin bad++; $display("FAIL scan_s1_engine got=%b exp=10", engine); end
        tick(4);
        total++; if (floor !== 2'd3) begin bad++; $display("FAIL scan_s5_floor got=%0d exp=3", floor); end
        total++; if (doors !== 4'b1000) begin bad++; $display("FAIL scan_s5_doors got=%b exp=1000", doors); end
        total++; if (engine !== 2'b00) begin bad++; $display("FAIL scan_s5_engine got=%b exp=00", engine); end
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL scan_s5_pending got=%b exp=0001", pending); end
        tick(3);
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL scan_s8_doors got=%b exp=0000", doors); end
        tick(1);
        total++; if (engine !== 2'b11) begin bad++; $display("FAIL scan_s9_engine got=%b exp=11", engine); end
        tick(4);
        total++; if (floor !== 2'd2 || doors !== 4'b0000 || engine !== 2'b11) begin
            bad++; $display("FAIL scan_pass2 got=%0d/%b/%b exp=2/0000/11", floor, doors, engine);
        end
        tick(4);
        total++; if (floor !== 2'd1 || doors !== 4'b0000 || engine !== 2'b11) begin
            bad++; $display("FAIL scan_pass1 got=%0d/%b/%b exp=1/0000/11", floor, doors, engine);
        end
        tick(4);
        total++; if (floor !== 2'd0 || doors !== 4'b0001 || engine !== 2'b00) begin
            bad++; $display("FAIL scan_ground got=%0d/%b/%b exp=0/0001/00", floor, doors, engine);
        end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL scan_s21_pending got=%b exp=0000", pending); end
        tick(3);
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL scan_s24_doors got=%b exp=0000", doors); end
    endtask

    task automatic test_pickup_and_reopen;
        interior_panel = 4'b1000;
        tick(1);
        interior_panel = '0;
        tick(1);
        total++; if (engine !== 2'b10) begin bad++; $display("FAIL pick_u1_engine got=%b exp=10", engine); end
        tick(1);
        interior_panel = 4'b0010;
        tick(1);
        interior_panel = 4'b0000;
        tick(1);
        interior_panel = 4'b0010;
        tick(1);
        interior_panel = '0;
        total++; if (floor !== 2'd1 || doors !== 4'b0010 || engine !== 2'b00) begin
            bad++; $display("FAIL pick_stop1 got=%0d/%b/%b exp=1/0010/00", floor, doors, engine);
        end
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL pick_clear_wins got=%b exp=1000", pending); end
        tick(2);
        exterior_panel = 4'b0010;
        tick(1);
        exterior_panel = '0;
        total++; if (doors !== 4'b0010) begin bad++; $display("FAIL reopen_u8_doors got=%b exp=0010", doors); end
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL reopen_pending got=%b exp=1000", pending); end
        tick(2);
        total++; if (doors !== 4'b0010) begin bad++; $display("FAIL reopen_u10_doors got=%b exp=0010", doors); end
        tick(1);
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL reopen_u11_doors got=%b exp=0000", doors); end
        tick(1);
        total++; if (engine !== 2'b10) begin bad++; $display("FAIL pick_resume_engine got=%b exp=10", engine); end
        tick(4);
        total++; if (floor !== 2'd2 || doors !== 4'b0000) begin
            bad++; $display("FAIL pick_pass2 got=%0d/%b exp=2/0000", floor, doors);
        end
        tick(4);
        total++; if (floor !== 2'd3 || doors !== 4'b1000 || engine !== 2'b00) begin
            bad++; $display("FAIL pick_top got=%0d/%b/%b exp=3/1000/00", floor, doors, engine);
        end
        tick(3);
        total++; if (doors !== 4'b0000 || engine !== 2'b00) begin
            bad++; $display("FAIL pick_close got=%b/%b exp=0000/00", doors, engine);
        end
    endtask

    task automatic test_reset_mid_move;
        RST = 1'b0;
        #2;
        RST = 1'b1;
        tick(1);
        interior_panel = 4'b1100;
        tick(1);
        interior_panel = '0;
        tick(1);
        total++; if (engine !== 2'b10 || pending !== 4'b1100) begin
            bad++; $display("FAIL mid_start got=%b/%b exp=10/1100", engine, pending);
        end
        tick(4);
        total++; if (floor !== 2'd1 || engine !== 2'b10) begin
            bad++; $display("FAIL mid_floor1 got=%0d/%b exp=1/10", floor, engine);
        end
        tick(1);
        RST = 1'b0;
        #1;
        total++; if (engine !== 2'b00) begin bad++; $display("FAIL mid_rst_engine got=%b exp=00", engine); end
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL mid_rst_doors got=%b exp=0000", doors); end
        total++; if (floor !== 2'd0) begin bad++; $display("FAIL mid_rst_floor got=%0d exp=0", floor); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL mid_rst_pending got=%b exp=0000", pending); end
        #2;
        RST = 1'b1;
        tick(10);
        total++; if (engine !== 2'b00 || floor !== 2'd0 || pending !== 4'b0000 || doors !== 4'b0000) begin
            bad++; $display("FAIL mid_after got=%b/%0d/%b/%b exp=00/0/0000/0000", engine, floor, pending, doors);
        end
    endtask

    task automatic test_idle_here;
        exterior_panel = 4'b0001;
        tick(1);
        exterior_panel = '0;
        total++; if (doors !== 4'b0001 || engine !== 2'b00) begin
            bad++; $display("FAIL here_open got=%b/%b exp=0001/00", doors, engine);
        end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL here_pending got=%b exp=0000", pending); end
        tick(2);
        total++; if (doors !== 4'b0001) begin bad++; $display("FAIL here_w2_doors got=%b exp=0001", doors); end
        tick(1);
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL here_w3_doors got=%b exp=0000", doors); end
    endtask

`ifdef ELEVATOR_DOOR_HOLD_EN
    task automatic test_door_hold;
        exterior_panel = 4'b0001;
        door_hold = 1'b1;
        tick(1);
        exterior_panel = '0;
        tick(9);
        door_hold = 1'b0;
        total++; if (doors !== 4'b0001) begin bad++; $display("FAIL hold_h9_doors got=%b exp=0001", doors); end
        tick(2);
        total++; if (doors !== 4'b0001) begin bad++; $display("FAIL hold_h11_doors got=%b exp=0001", doors); end
        tick(1);
        total++; if (doors !== 4'b0000) begin bad++; $display("FAIL hold_h12_doors got=%b exp=0000", doors); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_up;
        test_scan;
        test_pickup_and_reopen;
        test_reset_mid_move;
        test_idle_here;
`ifdef ELEVATOR_DOOR_HOLD_EN
        test_door_hold;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter FLOORS, default 4, number of served floors, legal 2..16.
REQ-002 Parameter TRAVEL_TICKS, default 4, CLK cycles to move one floor, legal >=1.
REQ-003 Parameter DOOR_TICKS, default 3, CLK cycles door stays open, legal >=1.
REQ-004 CLK  input  1  single rising-edge clock for all state.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 interior_panel  input  FLOORS  cabin buttons, bit i = floor i (LSB = ground), sampled every CLK edge.
REQ-007 exterior_panel  input  FLOORS  hall buttons, bit i = floor i, sampled every CLK edge.
REQ-008 engine  output  2  00 off, 10 up, 11 down, registered.
REQ-009 doors  output  FLOORS  one-hot-or-zero, 1 = door open at that floor, registered.
REQ-010 floor  output  clog2(FLOORS)  current cabin floor index, registered.
REQ-011 pending  output  FLOORS  latched outstanding requests, registered.

Function
REQ-012 States SHALL be IDLE, MOVE, DOOR_OPEN; a direction bit dir (1 up, 0 down) SHALL persist across states.
REQ-013 Each edge: pending |= interior_panel | exterior_panel, except the bit for the current floor in IDLE or DOOR_OPEN.
REQ-014 IDLE, request at current floor: next edge -> DOOR_OPEN, doors[floor]=1, door timer loaded.
REQ-015 IDLE, other pending: dir=1 and any pending above -> MOVE up; else any below -> MOVE down, dir=0; else any above -> MOVE up, dir=1; engine set on same edge.
REQ-016 IDLE, nothing pending: stay, engine=00, doors=0.
REQ-017 MOVE: travel counter counts TRAVEL_TICKS cycles, then floor +/-1 on that edge and counter reloads.
REQ-018 On arrival with pending[new floor]=1: same edge clears that bit, engine=00, doors[new floor]=1, -> DOOR_OPEN.
REQ-019 On arrival with no pending there: continue MOVE in dir if pending exists beyond; otherwise -> IDLE, engine=00.
REQ-020 Floor SHALL never exceed FLOORS-1 nor go below 0; dir forced 0 at top, 1 at ground.
REQ-021 DOOR_OPEN: doors held exactly DOOR_TICKS cycles, then doors=0 and -> IDLE; decision per REQ-015 on following edge.
REQ-022 Request for current floor during DOOR_OPEN SHALL reload the door timer and not set pending.
REQ-023 Arrival clear and new request for the same floor on the same edge: clear wins (request considered serviced).
REQ-024 engine and doors SHALL never be non-zero simultaneously.

Reset
REQ-025 RST low SHALL immediately force state=IDLE, floor=0, dir=1, engine=00, doors=0, pending=0, all counters 0.
REQ-026 Reset mid-MOVE or mid-DOOR_OPEN SHALL discard all pending requests; operation resumes from floor 0 after RST release.

Configuration
REQ-027 Macro ELEVATOR_DOOR_HOLD_EN defined: extra input door_hold (1 bit); while high in DOOR_OPEN the door timer reloads each cycle, door stays open.
REQ-028 Macro undefined: no door_hold port; door closes strictly after DOOR_TICKS cycles (REQ-021, REQ-022 only).

Verification (FLOORS=4, TRAVEL_TICKS=4, DOOR_TICKS=3)
REQ-029 Release reset, pulse interior_panel=0100 one cycle at edge t0 -> engine=10 after t1, floor=1 after t5, floor=2 after t9 with engine=00, doors=0100, pending=0000; doors=0000 after t12.
REQ-030 At floor 2 IDLE, dir=1, pulse exterior_panel=1001 -> goes up first: doors=1000 at floor 3, then engine=11, passes floors 2,1 without stopping, doors=0001 at floor 0.
REQ-031 During MOVE up from 0 toward 3, pulse interior_panel=0010 before floor-1 arrival edge -> stops at floor 1 (doors=0010), then continues to 3.
REQ-032 In DOOR_OPEN at floor 1, pulse exterior_panel=0010 on last open cycle -> door open 3 further cycles, pending[1] stays 0.
REQ-033 Assert RST low mid-MOVE between floors 1 and 2 with pending=1100 -> engine=00, doors=0, floor=0, pending=0000 immediately, no motion after release.
REQ-034 With ELEVATOR_DOOR_HOLD_EN, door_hold high 10 cycles in DOOR_OPEN -> doors stay set 10 cycles, close 3 cycles after door_hold falls.
